// File: rtl/fptoint.sv
// IEEE-754 single-precision to two's-complement fixed-point converter.
// A four-state FSM (IDLE, CLASSIFY, SHIFT, SIGN) gives a fixed 4-cycle latency
// on every path. The result has FRAC_BITS fractional bits, truncates toward
// zero and saturates on out-of-range or invalid operands.
module fptoint #(
    parameter int FRAC_BITS = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CLASSIFY = 2'd1;
    localparam logic [1:0] S_SHIFT    = 2'd2;
    localparam logic [1:0] S_SIGN     = 2'd3;

    localparam logic [1:0] P_ZERO = 2'd0;
    localparam logic [1:0] P_NORM = 2'd1;
    localparam logic [1:0] P_SAT  = 2'd2;
    localparam logic [1:0] P_NAN  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [31:0]       op_q, op_d;
    logic [1:0]        path_q, path_d;
    logic              pov_q, pov_d;
    logic signed [9:0] e_q, e_d;
    logic [31:0]       mag_q, mag_d;
    logic [31:0]       result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    // Saturation value chosen by the operand sign.
    function automatic logic [31:0] sat_value(input logic s);
        return s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction

    // Apply the sign to an unsigned magnitude; -0 naturally yields 0.
    function automatic logic [31:0] apply_sign(input logic s, input logic [31:0] m);
        return s ? (~m + 32'd1) : m;
    endfunction

    // Operand fields and unbiased, scaled exponent.
    logic              sign_w;
    logic [7:0]        exp_w;
    logic [22:0]       frac_w;
    logic signed [9:0] e_w;
    logic [31:0]       mant_w;
    logic [4:0]        lsh_w, rsh_w;
    logic [31:0]       shifted_w;

    assign sign_w = op_q[31];
    assign exp_w  = op_q[30:23];
    assign frac_w = op_q[22:0];
    assign e_w    = $signed({2'b00, exp_w}) - 10'sd127 + $signed(10'(FRAC_BITS));
    assign mant_w = {8'b0, 1'b1, frac_w};
    // Shift amounts are only meaningful on the normal path where 0 <= e <= 30.
    assign lsh_w  = 5'(e_q - 10'sd23);
    assign rsh_w  = 5'(10'sd23 - e_q);
    assign shifted_w = (e_q >= 10'sd23) ? (mant_w << lsh_w) : (mant_w >> rsh_w);

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = ovf_q;

    // Next-state and datapath decisions for each FSM state.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        path_d   = path_q;
        pov_d    = pov_q;
        e_d      = e_q;
        mag_d    = mag_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = dataa;
                    state_d = S_CLASSIFY;
                end
            end
            S_CLASSIFY: begin
                e_d     = e_w;
                state_d = S_SHIFT;
                if (exp_w == 8'hFF) begin
                    path_d = (frac_w != 23'd0) ? P_NAN : P_SAT;
                    pov_d  = 1'b1;
                end else if (exp_w == 8'h00 || e_w < 10'sd0) begin
                    path_d = P_ZERO;
                    pov_d  = 1'b0;
                end else if (e_w >= 10'sd31) begin
                    path_d = P_SAT;
                    // -2^31 exactly is representable, so it is not an overflow.
                    pov_d  = !(sign_w && e_w == 10'sd31 && frac_w == 23'd0);
                end else begin
                    path_d = P_NORM;
                    pov_d  = 1'b0;
                end
            end
            S_SHIFT: begin
                mag_d   = (path_q == P_NORM) ? shifted_w : 32'd0;
                state_d = S_SIGN;
            end
            default: begin
                case (path_q)
                    P_NAN:   result_d = 32'h7FFF_FFFF;
                    P_SAT:   result_d = sat_value(sign_w);
                    default: result_d = apply_sign(sign_w, mag_q);
                endcase
                ovf_d   = pov_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 32'd0;
            path_q   <= P_ZERO;
            pov_q    <= 1'b0;
            e_q      <= 10'sd0;
            mag_q    <= 32'd0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            path_q   <= path_d;
            pov_q    <= pov_d;
            e_q      <= e_d;
            mag_q    <= mag_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_fptoint.sv
// Bench for fptoint: two instances (FRAC_BITS=0 and FRAC_BITS=8) share the
// stimulus; an arithmetic model predicts every output on every cycle.
module tb_fptoint;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dataa = 32'd0;
    logic [31:0] res_w  [2];
    logic        busy_w [2];
    logic        done_w [2];
    logic        ovf_w  [2];

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    fptoint #(.FRAC_BITS(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .dataa(dataa),
        .result(res_w[0]), .busy(busy_w[0]), .done(done_w[0]), .overflow(ovf_w[0])
    );
    fptoint #(.FRAC_BITS(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .dataa(dataa),
        .result(res_w[1]), .busy(busy_w[1]), .done(done_w[1]), .overflow(ovf_w[1])
    );

    function automatic int frac_of(input int lane);
        return (lane == 0) ? 0 : 8;
    endfunction

    // Value-level model: x * 2^frac, truncated toward zero, range-checked.
    // Returns {overflow, result}.
    function automatic logic [32:0] model(input logic [31:0] x, input int frac);
        int     ex;
        int     s;
        longint mag;
        longint v;
        ex = int'(x[30:23]);
        if (ex == 255) begin
            if (x[22:0] != 23'd0) return {1'b1, 32'h7FFF_FFFF};
            return x[31] ? {1'b1, 32'h8000_0000} : {1'b1, 32'h7FFF_FFFF};
        end
        if (ex == 0) return 33'd0;
        s = ex - 150 + frac;
        if (s > 32) mag = 64'sh4000_0000_0000_0000;
        else if (s >= 0) mag = longint'({1'b1, x[22:0]}) << s;
        else mag = longint'({1'b1, x[22:0]}) >> (-s);
        v = x[31] ? -mag : mag;
        if (v > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
        if (v < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        return {1'b0, v[31:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a request is taken when no conversion is in flight,
    // and the answer appears three edges later for one cycle.
    int          remaining;
    logic        m_done;
    logic [32:0] pend  [2];
    logic [31:0] m_res [2];
    logic        m_ovf [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= 0;
            m_done    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_res[i] <= 32'd0;
                m_ovf[i] <= 1'b0;
                pend[i]  <= 33'd0;
            end
        end else begin
            m_done <= 1'b0;
            if (remaining > 0) begin
                remaining <= remaining - 1;
                if (remaining == 1) begin
                    m_done <= 1'b1;
                    for (int i = 0; i < 2; i++) begin
                        m_res[i] <= pend[i][31:0];
                        m_ovf[i] <= pend[i][32];
                    end
                end
            end else if (start) begin
                remaining <= 3;
                for (int i = 0; i < 2; i++) pend[i] <= model(dataa, frac_of(i));
            end
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("done[%0d]", i), 32'(done_w[i]), 32'(m_done));
                check($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'(remaining != 0));
                check($sformatf("result[%0d]", i), res_w[i], m_res[i]);
                check($sformatf("overflow[%0d]", i), 32'(ovf_w[i]), 32'(m_ovf[i]));
            end
        end
    end

    logic [31:0] vec [16] = '{
        32'h3FC00000, 32'hC1200000, 32'h3F000000, 32'h80000000,
        32'h4F000000, 32'hCF000000, 32'hFF800000, 32'h7FC00000,
        32'hBE800000, 32'h40400000, 32'h7F800000, 32'h00400000,
        32'h4EFFFFFF, 32'hCF000001, 32'h3F800000, 32'hFFC00001
    };

    task automatic convert(input logic [31:0] x);
        @(posedge clk); #2;
        start = 1'b1;
        dataa = x;
        @(posedge clk); #2;
        start = 1'b0;
        dataa = 32'hDEAD_BEEF;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        logic [32:0] m;
        // Model pins with hand-computed values.
        m = model(32'h3FC00000, 0); check("pin 1.5", m[31:0], 32'h00000001);
        m = model(32'hC1200000, 0); check("pin -10", m[31:0], 32'hFFFFFFF6);
        m = model(32'h3F000000, 0); check("pin 0.5", m[31:0], 32'h00000000);
        m = model(32'h80000000, 0); check("pin -0", m[31:0], 32'h00000000);
        m = model(32'h4F000000, 0); check("pin 2^31", m, {1'b1, 32'h7FFFFFFF});
        m = model(32'hCF000000, 0); check("pin -2^31", m, {1'b0, 32'h80000000});
        m = model(32'hFF800000, 0); check("pin -inf", m, {1'b1, 32'h80000000});
        m = model(32'h7FC00000, 0); check("pin nan", m, {1'b1, 32'h7FFFFFFF});
        m = model(32'h3FC00000, 8); check("pin 1.5 q8", m[31:0], 32'h00000180);
        m = model(32'hBE800000, 8); check("pin -0.25 q8", m[31:0], 32'hFFFFFFC0);

        #1 reset = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        check("reset result", res_w[0], 32'd0);
        check("reset busy", 32'(busy_w[0]), 32'd0);

        // 1.5 with explicit done timing: accepted at edge k.
        @(posedge clk); #2;
        start = 1'b1;
        dataa = 32'h3FC00000;
        @(posedge clk); #1;                      // edge k
        start = 1'b0;
        @(posedge clk); #1; check("done k+1", 32'(done_w[0]), 32'd0);
        @(posedge clk); #1; check("done k+2", 32'(done_w[0]), 32'd0);
        @(posedge clk); #1; check("done k+3", 32'(done_w[0]), 32'd1);
        check("result 1.5", res_w[0], 32'h00000001);
        check("result 1.5 q8", res_w[1], 32'h00000180);
        @(posedge clk); #1; check("done k+4", 32'(done_w[0]), 32'd0);
        check("hold 1.5", res_w[0], 32'h00000001);

        for (int i = 0; i < 16; i++) convert(vec[i]);

        // Reset in the middle of a conversion.
        @(posedge clk); #2;
        start = 1'b1;
        dataa = 32'hC1200000;
        @(posedge clk); #2;                      // edge k
        start = 1'b0;
        @(posedge clk); #2;                      // edge k+1
        reset = 1'b1;
        #1;
        check("abort busy", 32'(busy_w[0]), 32'd0);
        check("abort result", res_w[0], 32'd0);
        check("abort done", 32'(done_w[0]), 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        convert(32'h40400000);
        check("after abort 3.0", res_w[0], 32'h00000003);
        check("after abort 3.0 q8", res_w[1], 32'h00000300);

        // Back-to-back with start held and data changing every cycle.
        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #2;
            start = 1'b1;
            dataa = vec[(i * 5) % 16];
        end
        @(posedge clk); #2;
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fptoint.md
FPTOINT -- requirements
Module: fptoint

Interface
REQ-001 Parameter FRAC_BITS, default 0, number of fractional bits in the fixed-point result; legal range 0..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to convert dataa; sampled only in IDLE.
REQ-005 dataa  input  32  IEEE-754 single-precision operand (sign 31, exponent 30:23, fraction 22:0).
REQ-006 result  output  32  two's-complement fixed-point value, FRAC_BITS fractional bits.
REQ-007 busy  output  1  high while a conversion is in flight (any state other than IDLE).
REQ-008 done  output  1  one-cycle pulse; result and overflow are valid from this cycle on.
REQ-009 overflow  output  1  saturation or invalid-operand flag for the last conversion.

Function
REQ-010 The FSM SHALL have states IDLE, CLASSIFY, SHIFT and SIGN, encoded in a 2-bit state register.
REQ-011 IDLE: on a clock edge with start=1, the block SHALL capture dataa into an internal operand register and go to CLASSIFY; start=0 stays in IDLE.
REQ-012 start SHALL be ignored while busy=1; the captured operand SHALL NOT change mid-conversion.
REQ-013 CLASSIFY SHALL compute e = exponent - 127 + FRAC_BITS as a signed 10-bit value, and SHALL select one of the zero, saturate, NaN or normal paths; it then goes to SHIFT.
REQ-014 Zero path: exponent=0 (zero or denormal), or e<0, SHALL give magnitude 0 and overflow=0.
REQ-015 NaN path: exponent=255 with fraction!=0 SHALL give result 0x7FFFFFFF and overflow=1, regardless of sign.
REQ-016 Saturate path (exponent=255 with fraction=0, or e>=31): the result SHALL be 0x7FFFFFFF for sign=0 or 0x80000000 for sign=1, with overflow=1.
REQ-017 Saturate exception: sign=1, e=31 and fraction=0 is exactly -2^31; it SHALL give 0x80000000 with overflow=0.
REQ-018 Normal path (0<=e<=30): the mantissa {1,fraction} (24 bits) SHALL be shifted left by e-23 when e>=23, else right by 23-e, with truncation toward zero.
REQ-019 The shift SHALL complete in the SHIFT state into a 32-bit magnitude register; the state then goes to SIGN.
REQ-020 SIGN SHALL load result with the two's complement of the magnitude if sign=1, else with the magnitude itself.
REQ-021 In SIGN, the saturate and NaN paths SHALL bypass the magnitude and load their fixed values.
REQ-022 In SIGN, the block SHALL register done=1 and overflow, and return to IDLE.
REQ-023 Latency SHALL be fixed at 4 cycles on every path: with start sampled at edge k, done is high in the cycle after edge k+3.
REQ-024 done SHALL be high for exactly one cycle.
REQ-025 result and overflow SHALL hold their values until the SIGN state of the next conversion.
REQ-026 A start asserted in the cycle where done=1 SHALL be accepted, since the FSM is already in IDLE; back-to-back conversions therefore run every 4 cycles.
REQ-027 A negative zero result (sign=1 with magnitude 0) SHALL produce 0x00000000.

Reset
REQ-028 While reset=1, immediately and independently of clk, the block SHALL force state=IDLE, result=0, done=0, overflow=0 and busy=0, and SHALL clear the operand and magnitude registers.
REQ-029 A reset asserted mid-conversion SHALL abort it with no done pulse; the first start after reset is released SHALL behave as a fresh conversion.

Verification
REQ-030 FRAC_BITS=0, dataa=0x3FC00000 (1.5), start at edge k -> result=0x00000001, overflow=0, done high only in the cycle after edge k+3.
REQ-031 FRAC_BITS=0, dataa=0xC1200000 (-10.0) -> result=0xFFFFFFF6; dataa=0x3F000000 (0.5) -> 0x00000000; dataa=0x80000000 -> 0x00000000.
REQ-032 FRAC_BITS=0: dataa=0x4F000000 -> 0x7FFFFFFF with overflow=1; dataa=0xCF000000 -> 0x80000000 with overflow=0; dataa=0xFF800000 -> 0x80000000 with overflow=1; dataa=0x7FC00000 -> 0x7FFFFFFF with overflow=1.
REQ-033 FRAC_BITS=8, dataa=0x3FC00000 -> result=0x00000180; dataa=0xBE800000 (-0.25) -> 0xFFFFFFC0.
REQ-034 Pulse reset at edge k+2 of a conversion -> busy=0 and result=0 immediately, no done pulse; a new start with 0x40400000 (3.0) -> result=0x00000003 after 4 cycles.
REQ-035 Back-to-back: start held high continuously with dataa changing each cycle -> only the values present at accepted edges are converted, one done every 4 cycles, and start during busy has no effect.
